uart_reg_bridge: RTL
====================

UART_REG_BRIDGE -- requirements
Module: uart_reg_bridge

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 8, meaning register address width; legal range 1..16.
REQ-002 The module SHALL have parameter DATA_BYTES, default 1, meaning register width in bytes; legal range 1..4, with DATA_W = 8*DATA_BYTES.
REQ-003 The module SHALL have parameter TIMEOUT_CYC, default 500000, meaning the inter-byte timeout in clk cycles; minimum 2.
REQ-004 The module SHALL have these ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- rx_done_i  in  1  one-cycle pulse; rx_data_i holds a valid byte.
- rx_data_i  in  8  received byte.
- tx_done_i  in  1  one-cycle pulse; transmitter finished the previous byte.
- tx_wr_o  out  1  one-cycle pulse requesting transmission of tx_data_o.
- tx_data_o  out  8  byte to transmit.
- reg_addr_o  out  ADDR_W  register address.
- reg_wdata_o  out  DATA_W  write data.
- reg_wr_o  out  1  one-cycle write strobe.
- reg_rd_o  out  1  one-cycle read strobe.
- reg_rdata_i  in  DATA_W  read data, valid exactly 1 cycle after reg_rd_o.
- err_o  out  2  sticky flags: bit0 = frame error, bit1 = overrun.

Function
REQ-005 The frame format SHALL be: CMD byte, then ADDR_BYTES = ceil(ADDR_W/8) address bytes MSB-first, then, for a write only, DATA_BYTES data bytes MSB-first.
REQ-006 Commands SHALL be 0x57 (write) and 0x52 (read); any other CMD byte in IDLE SHALL cause a transmitted NAK 0x15 followed by a return to IDLE, and SHALL set err_o[0].
REQ-007 The FSM states SHALL be IDLE, ADDR, WDATA, WRITE, READ, RCAP, TXSEND and TXWAIT.
REQ-008 The FSM transitions SHALL be:
- IDLE -> ADDR on a valid CMD.
- ADDR -> WDATA (write) or READ (read) after the last address byte.
- WDATA -> WRITE after the last data byte.
- Address and data bytes SHALL be shifted in left by 8 bits per byte; address bits above ADDR_W SHALL be discarded.
REQ-009 WRITE SHALL assert reg_wr_o for exactly 1 cycle with reg_addr_o and reg_wdata_o stable, then load ACK 0x06 into the response and go to TXSEND.
REQ-010 READ SHALL assert reg_rd_o for 1 cycle; RCAP SHALL capture reg_rdata_i on the next cycle into the response shift register, set the byte count to DATA_BYTES, and go to TXSEND.
REQ-011 TXSEND SHALL pulse tx_wr_o for 1 cycle with tx_data_o equal to the current response byte (MSB-first), then go to TXWAIT.
REQ-012 TXWAIT SHALL wait for tx_done_i, then go to TXSEND if bytes remain, otherwise to IDLE.
REQ-013 tx_done_i SHALL be ignored in all states other than TXWAIT.
REQ-014 tx_data_o, reg_addr_o and reg_wdata_o SHALL hold their values between strobes.
REQ-015 In ADDR or WDATA, a gap of TIMEOUT_CYC cycles without rx_done_i SHALL discard the partial frame, set err_o[0], and return to IDLE without any register access or TX.
REQ-016 The timeout counter SHALL clear on every accepted byte and on entry to ADDR; it SHALL saturate and SHALL NOT wrap.
REQ-017 rx_done_i received in WRITE, READ, RCAP, TXSEND or TXWAIT SHALL be dropped and SHALL set err_o[1]; it SHALL NOT start a new frame.
REQ-018 The error flags in err_o SHALL be cleared only by reset.
REQ-019 Latency SHALL be: the reg_wr_o pulse occurs 1 cycle after the rx_done_i of the last data byte; reg_rd_o occurs 1 cycle after the rx_done_i of the last address byte; the first tx_wr_o occurs 1 cycle after the WRITE state, or 1 cycle after the RCAP state for a read.
REQ-020 reg_wr_o and reg_rd_o SHALL never be asserted in the same cycle, and no more than one frame SHALL be in flight at a time.

Reset
REQ-021 While rst_n = 0 at a clk edge, the state SHALL become IDLE, and tx_wr_o, reg_wr_o, reg_rd_o, tx_data_o, reg_addr_o, reg_wdata_o, err_o and all counters and shift registers SHALL become 0.
REQ-022 Reset asserted mid-frame or mid-response SHALL abort the operation with no further strobes; the first byte after reset release SHALL be treated as a CMD.

Verification
REQ-023 With ADDR_W=8, DATA_BYTES=2, rx bytes 0x57 0x10 0xAB 0xCD SHALL produce exactly one reg_wr_o with addr 0x10 and wdata 0xABCD, followed by tx 0x06.
REQ-024 In the same configuration with reg_rdata_i = 0x1234, rx 0x52 0x10 SHALL produce one reg_rd_o with addr 0x10, then tx 0x12; the second tx_wr_o SHALL occur only after tx_done_i, with tx 0x34.
REQ-025 rx 0x41 SHALL produce tx 0x15, err_o = 2'b01, and no register strobe.
REQ-026 With TIMEOUT_CYC=20, rx 0x57 0x10 followed by 20 idle cycles SHALL set err_o[0] with no strobes; a subsequent valid read frame SHALL complete normally.
REQ-027 An rx byte injected during TXWAIT SHALL set err_o[1] and SHALL leave the response bytes unchanged.
REQ-028 rst_n = 0 asserted after the 0xAB byte of a write frame SHALL produce no reg_wr_o, all outputs 0, and a subsequent frame SHALL be accepted.

Source files
------------

// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge: turns UART command frames into register-bus reads/writes and sends back ACK/NAK/read data
// Ports:
//   clk, rst_n               clock (rising edge), synchronous active-low reset
//   rx_done_i, rx_data_i     received-byte strobe and byte
//   tx_done_i                transmitter finished the previous byte
//   tx_wr_o, tx_data_o       transmit request strobe and byte
//   reg_addr_o, reg_wdata_o  register address and write data, held between strobes
//   reg_wr_o, reg_rd_o       one-cycle write / read strobes
//   reg_rdata_i              read data, valid one cycle after reg_rd_o
//   err_o                    sticky flags {overrun, frame error}
module uart_reg_bridge #(
    parameter int ADDR_W      = 8,
    parameter int DATA_BYTES  = 1,
    parameter int TIMEOUT_CYC = 500000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rx_done_i,
    input  logic [7:0]              rx_data_i,
    input  logic                    tx_done_i,
    output logic                    tx_wr_o,
    output logic [7:0]              tx_data_o,
    output logic [ADDR_W-1:0]       reg_addr_o,
    output logic [8*DATA_BYTES-1:0] reg_wdata_o,
    output logic                    reg_wr_o,
    output logic                    reg_rd_o,
    input  logic [8*DATA_BYTES-1:0] reg_rdata_i,
    output logic [1:0]              err_o
);
    localparam int DATA_W     = 8 * DATA_BYTES;
    localparam int ADDR_BYTES = (ADDR_W + 7) / 8;
    localparam int TMO_W      = $clog2(TIMEOUT_CYC);
    localparam logic [2:0] ADDR_LAST = 3'(ADDR_BYTES - 1);
    localparam logic [2:0] DATA_LAST = 3'(DATA_BYTES - 1);
    localparam logic [2:0] DATA_CNT  = 3'(DATA_BYTES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0] CMD_WR = 8'h57;
    localparam logic [7:0] CMD_RD = 8'h52;
    localparam logic [7:0] ACK    = 8'h06;
    localparam logic [7:0] NAK    = 8'h15;

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, WRITE, READ, RCAP, TXSEND, TXWAIT} state_t;

    state_t            state;
    logic              is_wr;
    logic [2:0]        cnt;
    logic [TMO_W-1:0]  tmo;
    logic [ADDR_W-1:0] addr_sh;
    logic [DATA_W-1:0] data_sh;
    logic [DATA_W-1:0] resp;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            is_wr       <= 1'b0;
            cnt         <= '0;
            tmo         <= '0;
            addr_sh     <= '0;
            data_sh     <= '0;
            resp        <= '0;
            tx_wr_o     <= 1'b0;
            tx_data_o   <= '0;
            reg_addr_o  <= '0;
            reg_wdata_o <= '0;
            reg_wr_o    <= 1'b0;
            reg_rd_o    <= 1'b0;
            err_o       <= '0;
        end else begin
            tx_wr_o  <= 1'b0;
            reg_wr_o <= 1'b0;
            reg_rd_o <= 1'b0;
            // bytes arriving while a command executes or answers are dropped
            if (rx_done_i && state inside {WRITE, READ, RCAP, TXSEND, TXWAIT}) err_o[1] <= 1'b1;
            case (state)
                IDLE: if (rx_done_i) begin
                    is_wr <= rx_data_i == CMD_WR;
                    tmo   <= '0;
                    if (rx_data_i == CMD_WR || rx_data_i == CMD_RD) begin
                        cnt   <= '0;
                        state <= ADDR;
                    end else begin
                        err_o[0]  <= 1'b1;
                        tx_data_o <= NAK;
                        tx_wr_o   <= 1'b1;
                        cnt       <= 3'd1;
                        state     <= TXSEND;
                    end
                end
                ADDR: if (rx_done_i) begin
                    // shifting through a cast drops address bits above ADDR_W
                    addr_sh <= ADDR_W'({addr_sh, rx_data_i});
                    tmo     <= '0;
                    cnt     <= (cnt == ADDR_LAST) ? 3'd0 : cnt + 3'd1;
                    if (cnt == ADDR_LAST) begin
                        if (is_wr) state <= WDATA;
                        else begin
                            reg_addr_o <= ADDR_W'({addr_sh, rx_data_i});
                            reg_rd_o   <= 1'b1;
                            state      <= READ;
                        end
                    end
                end else if (tmo == TMO_LAST) begin
                    err_o[0] <= 1'b1;
                    state    <= IDLE;
                end else tmo <= tmo + TMO_W'(1);
                WDATA: if (rx_done_i) begin
                    data_sh <= DATA_W'({data_sh, rx_data_i});
                    tmo     <= '0;
                    cnt     <= (cnt == DATA_LAST) ? 3'd0 : cnt + 3'd1;
                    if (cnt == DATA_LAST) begin
                        reg_addr_o  <= addr_sh;
                        reg_wdata_o <= DATA_W'({data_sh, rx_data_i});
                        reg_wr_o    <= 1'b1;
                        state       <= WRITE;
                    end
                end else if (tmo == TMO_LAST) begin
                    err_o[0] <= 1'b1;
                    state    <= IDLE;
                end else tmo <= tmo + TMO_W'(1);
                WRITE: begin
                    tx_data_o <= ACK;
                    tx_wr_o   <= 1'b1;
                    cnt       <= 3'd1;
                    state     <= TXSEND;
                end
                READ: state <= RCAP;
                RCAP: begin
                    // first byte goes out now, the rest stays queued MSB-first in resp
                    tx_data_o <= reg_rdata_i[DATA_W-1 -: 8];
                    resp      <= reg_rdata_i << 8;
                    tx_wr_o   <= 1'b1;
                    cnt       <= DATA_CNT;
                    state     <= TXSEND;
                end
                TXSEND: begin
                    cnt   <= cnt - 3'd1;
                    state <= TXWAIT;
                end
                TXWAIT: if (tx_done_i) begin
                    if (cnt != 3'd0) begin
                        tx_data_o <= resp[DATA_W-1 -: 8];
                        resp      <= resp << 8;
                        tx_wr_o   <= 1'b1;
                        state     <= TXSEND;
                    end else state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
